// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause bit positions,
// exception codes and the default exception entry address.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  // SR bit positions
  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;

  // Cause bit positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // Exception codes carried in Cause.ExcCode
  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky pending flag; pending is cleared only by
// rewriting Compare, never by exception entry.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pend
);

  logic wr_count;
  logic wr_compare;

  assign wr_count   = we && (addr == REG_COUNT);
  assign wr_compare = we && (addr == REG_COMPARE);

  // Free-running counter, Compare register and pending flag.
  // NOTE: non-blocking assignments so every register samples pre-edge values
  // (pend compares the old count against the old compare).
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      pend    <= 1'b0;
    end else begin
      count <= wr_count ? din : count + 32'd1;
      if (wr_compare) begin
        compare <= din;
      end
      if (wr_compare) begin
        pend <= 1'b0;
      end else if ((count == compare) && (compare != '0)) begin
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside the M stage: raises Req,
// captures EPC/Cause on entry, serves mtc0/mfc0/eret and hosts the timer.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = DEFAULT_HANDLER_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [31:0] M_PC,
  input  logic        M_Delayslot,
  input  logic [4:0]  M_EXCcode,
  input  logic        M_eret,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] redirect_pc,
  output logic        exl
);

  // SR fields
  logic [5:0]  im;
  logic        ie;
  // Cause fields
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc;
  logic [31:0] epc;

  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_pend;
  logic        int_req;
  logic        exc_req;
  logic        timer_we;

  assign int_req     = (|(ip & im)) & ie & ~exl;
  assign exc_req     = (M_EXCcode != 5'd0) & ~exl;
  assign Req         = int_req | exc_req;
  assign redirect_pc = Req ? HANDLER_PC : epc;

  // A nullified instruction must not write Count/Compare either.
  assign timer_we = we & ~Req;

  cp0_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .we      (timer_we),
    .addr    (addr),
    .din     (din),
    .count   (count),
    .compare (compare),
    .pend    (timer_pend)
  );

  // mfc0 read mux, combinational from addr.
  // NOTE: dout gets a default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    dout = '0;
    case (addr)
      REG_SR: begin
        dout[SR_IM_HI:SR_IM_LO] = im;
        dout[SR_EXL]            = exl;
        dout[SR_IE]             = ie;
      end
      REG_CAUSE: begin
        dout[CAUSE_BD]                  = bd;
        dout[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        dout[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
      end
      REG_EPC:     dout = epc;
      REG_COUNT:   dout = count;
      REG_COMPARE: dout = compare;
      default:     dout = '0;
    endcase
  end

  // SR/Cause/EPC update: exception entry wins over eret and mtc0.
  always_ff @(posedge clk) begin
    if (reset) begin
      im  <= '0;
      ie  <= 1'b0;
      exl <= 1'b0;
      bd  <= 1'b0;
      ip  <= '0;
      exc <= '0;
      epc <= '0;
    end else begin
      ip <= {HWInt[5] | timer_pend, HWInt[4:0]};
      if (Req) begin
        exl <= 1'b1;
        bd  <= M_Delayslot;
        exc <= int_req ? EXC_INT : M_EXCcode;
        epc <= M_Delayslot ? (M_PC - 32'd4) : M_PC;
      end else begin
        if (M_eret) begin
          exl <= 1'b0;
        end
        if (we) begin
          case (addr)
            REG_SR: begin
              im  <= din[SR_IM_HI:SR_IM_LO];
              exl <= din[SR_EXL];
              ie  <= din[SR_IE];
            end
            REG_EPC: epc <= din;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. It sits beside the M stage. It evaluates the M-stage exception code and external interrupts against the SR/Cause state, and raises `Req`, which every pipeline register (F/D, D/E, E/M, M/W) samples to load PC = handler and nullify its contents. It also holds the architectural SR, Cause, EPC, Count and Compare registers, and serves `mtc0`, `mfc0` and `eret`.

## Interface
- `HANDLER_PC`, 32'h0000_4180, exception entry address driven on `redirect_pc` when `Req`=1
- `clk` in 1 — single clock; all state updates on posedge
- `reset` in 1 — synchronous, active-high
- `we` in 1 — `mtc0` commit from M stage
- `addr` in 5 — CP0 register number for `mtc0`/`mfc0`
- `din` in 32 — `mtc0` write data
- `dout` out 32 — `mfc0` read data, combinational from `addr`
- `M_PC` in 32 — PC of M-stage instruction
- `M_Delayslot` in 1 — M-stage instruction is in a branch delay slot
- `M_EXCcode` in 5 — accumulated exception code; 0 = none
- `M_eret` in 1 — `eret` in M stage
- `HWInt` in 6 — external interrupt lines, level-sensitive
- `Req` out 1 — take exception/interrupt this cycle, combinational
- `redirect_pc` out 32 — `HANDLER_PC` when `Req`=1, else EPC (target for `eret`)
- `exl` out 1 — SR.EXL

## Operation
- SR (reg 12): IM[15:10], EXL[1], IE[0]; all other bits read 0 and ignore writes.
- Cause (reg 13): BD[31], IP[15:10], ExcCode[6:2]; read-only to `mtc0` (writes ignored).
- EPC (reg 14), Count (reg 9) and Compare (reg 11) are full 32-bit registers. Any other address reads 0.
- IP update: IP ← {HWInt[5] | timer_pend, HWInt[4:0]} on every edge, unconditionally, including during EXL.
- Interrupt and exception requests:
  - IntReq = |(IP & IM) & IE & ~EXL, using registered IP.
  - ExcReq = (M_EXCcode ≠ 0) & ~EXL.
  - Req = IntReq | ExcReq.
- On an edge with Req=1:
  - EXL ← 1; BD ← M_Delayslot.
  - ExcCode ← 0 if IntReq, else M_EXCcode. Interrupt has priority over exception.
  - EPC ← M_Delayslot ? M_PC−4 : M_PC (mod 2^32, no alignment).
  - Any simultaneous `we` is dropped, because the instruction is nullified.
- On an edge with Req=0:
  - `M_eret` → EXL ← 0.
  - `we` → write the addressed register. Writing EPC or SR in the same cycle as `M_eret` is allowed; both take effect.
- Count:
  - Increments by 1 each edge, wrapping 0xFFFF_FFFF→0.
  - `mtc0` to 9 loads `din` instead of incrementing.
- timer_pend:
  - Set on an edge where Count == Compare and Compare ≠ 0.
  - Cleared by `mtc0` to 11, which has priority over set in the same cycle.
  - Not cleared by exception entry.
- The pipeline guarantees `M_EXCcode`=0 whenever M holds a bubble inserted by flush with no prior exception.

## Timing
- Reset values: SR, Cause, EPC, Count, Compare and timer_pend are all 0. `exl`=0. `dout`=0 for any `addr` after reset.
- `Req`, `redirect_pc` and `dout` are combinational, with zero latency. Pipeline registers act on `Req` at the same edge that CP0 latches EPC and Cause.
- A register write is visible on `dout` in the cycle after the `we` edge. There is no same-cycle bypass.
- An HWInt rise is reflected in IP one edge later, so `Req` asserts one cycle after the rise at the earliest.
- After the Req edge, EXL=1 blocks further Req until an `eret` edge. The first Req can reassert in the cycle after that `eret` edge.
- Reset overrides every event in the same cycle.

## Structure
- Package `cp0_pkg`:
  - Register numbers 9/11/12/13/14.
  - SR/Cause bit positions.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
  - Default `HANDLER_PC`.
- Sub-module `cp0_timer`: Count, Compare and timer_pend, with ports clk, reset, we, addr, din, count, compare, pend.

## Test plan
- **Reset/read-back:** after reset, `mtc0` SR←0x0000_FC01 → `mfc0` 12 returns 0x0000_FC01. `mtc0` 12 ← 0xFFFF_FFFF → returns 0x0000_FC03.
- **Exception in delay slot:** M_PC=0x3008, M_Delayslot=1, M_EXCcode=12 → Req=1 and redirect_pc=0x4180 in that cycle. Next cycle: EPC=0x3004, Cause=0x8000_0030, exl=1.
- **Interrupt priority and write drop:** SR=0x0000_0401, HWInt[0]=1, M_EXCcode=10, with a simultaneous `we` to EPC → ExcCode=0, IP[10]=1, and EPC=M_PC (the write is dropped).
- **EXL masking/eret:** with EXL=1, M_EXCcode=4 → Req=0. `M_eret` edge → exl=0, redirect_pc=EPC, and a pending enabled interrupt raises Req the next cycle.
- **Timer:** Compare←5 with Count=0 → timer_pend sets when Count=5. With SR=0x0000_8001, Req follows after IP[15] sets. `mtc0` Compare clears timer_pend.
- **Mid-operation reset:** reset asserted in the Req cycle → all registers 0 next cycle and no EPC capture.
